mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage load/store unit. Consumes the EX/MEM pipeline register outputs (address, store data, control, funct3).
- Drives a valid/ready data-memory request channel and accepts a valid-only response channel.
- Formats load data and produces a stall that holds IF..EX/MEM until each access completes.
- Sits between the EX/MEM register and the MEM/WB register.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- alu_result_in  in  32  effective byte address from EX/MEM.
- rs2_data_in  in  32  store data from EX/MEM.
- mem_read_in  in  1  load request from EX/MEM.
- mem_write_in  in  1  store request from EX/MEM.
- reg_write_in  in  1  write-back enable from EX/MEM.
- funct3_in  in  3  access size and sign from EX/MEM.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_addr  out  32  word address, {alu_result_in[31:2],2'b00}.
- dmem_we  out  1  1 = store.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rsp_valid  in  1  response (load data or store ack).
- dmem_rsp_data  in  32  raw read word.
- mem_rdata_out  out  32  extended load data to MEM/WB.
- reg_write_out  out  1  reg_write_in gated with !fault_out.
- fault_out  out  1  misaligned address or illegal funct3.
- stall_out  out  1  hold upstream pipeline (deasserts EX/MEM enable).
- bus_err_out  out  1  response timeout; tied 0 when MEM_TIMEOUT_EN is undefined.

Behaviour:
- Reset (rst=1 at a clk edge): FSM to IDLE; mem_rdata_out=0; bus_err_out=0; watchdog counter=0. Combinational outputs follow the IDLE state.
- An access is active when mem_read_in|mem_write_in.
- Fault conditions:
  - funct3 in {011,110,111} (illegal).
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- A faulting access issues no request, has stall_out=0 and reg_write_out=0, and completes in 0 extra cycles. fault_out is combinational and is 0 when no access is active.
- Byte enables (loads drive the same dmem_be):
  - byte: 0001<<addr[1:0].
  - half: 0011<<addr[1:0].
  - word: 1111.
- Store data: SB replicates rs2[7:0] into all 4 lanes; SH replicates rs2[15:0] into both halves; SW passes rs2 unchanged.
- Load formatting: select the byte/half lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- FSM states IDLE, WAIT_RSP, DONE:
  - IDLE:
    - Active non-faulting access: dmem_req_valid=1 and stall_out=1.
    - If dmem_req_ready=1 -> WAIT_RSP; otherwise stay in IDLE with request fields held stable.
    - No access: all outputs idle, stall_out=0.
  - WAIT_RSP:
    - dmem_req_valid=0, stall_out=1.
    - On dmem_rsp_valid: for a load, register the formatted data into mem_rdata_out; then -> DONE.
    - A response arriving in the same cycle as acceptance is not legal; the earliest legal response is the cycle after acceptance.
  - DONE:
    - stall_out=0; no new request is issued (the EX/MEM inputs still show the same instruction).
    - -> IDLE next cycle.
- Latency: a zero-wait memory gives 2 stall cycles per access.
- mem_rdata_out holds its value until the next load completes.
- dmem_rsp_valid seen in IDLE or DONE is ignored.
- Reset mid-WAIT_RSP: return to IDLE and drop any outstanding response. Memory-side cleanup is out of scope.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter runs in WAIT_RSP and clears on leaving WAIT_RSP.
  - On reaching TIMEOUT_CYCLES-1 without a response: go to DONE with mem_rdata_out=0 and bus_err_out=1 for the DONE cycle only.
- MEM_TIMEOUT_EN undefined: no counter is built, WAIT_RSP waits indefinitely, bus_err_out is constant 0.

Decomposition:
- Package mem_pkg holds:
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - State enum mau_state_t {IDLE, WAIT_RSP, DONE}.
- Natural sub-module: load_align, combinational raw word + addr[1:0] + funct3 -> extended 32-bit value.

Test Plan:
- SW addr 0x100, rs2 0xDEADBEEF, ready=1, response 1 cycle later -> be=1111, wdata=DEADBEEF, we=1, stall high exactly 2 cycles.
- LB addr 0x203, rsp_data 0x80112233 -> be=1000, mem_rdata_out=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- LHU addr 0x101 -> fault_out=1, reg_write_out=0, no dmem_req_valid, stall_out=0.
- LW with ready low 3 cycles, then rsp 2 cycles after acceptance -> valid held with stable addr/be, stall asserted throughout, deasserts in DONE.
- rst pulsed during WAIT_RSP, late rsp_valid in IDLE -> FSM in IDLE, mem_rdata_out=0, response ignored.
- (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8) LW accepted, no rsp -> DONE after 8 WAIT_RSP cycles, bus_err_out=1 for one cycle, mem_rdata_out=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// FSM state type and funct3 decode helpers.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RSP,
        DONE
    } mau_state_t;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Only halfword and word accesses carry alignment constraints.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic r;
        case (f3[1:0])
            F3_LH[1:0]: r = off[0];
            F3_LW[1:0]: r = (off != 2'b00);
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load formatter: picks the byte/half lane addressed by off from the raw
// memory word and sign- or zero-extends it according to funct3.
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_raw,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic signed [7:0]  w_byte;
    logic signed [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_raw[7:0];
            2'd1:    w_byte = i_raw[15:8];
            2'd2:    w_byte = i_raw[23:16];
            default: w_byte = i_raw[31:24];
        endcase
        w_half = i_off[1] ? i_raw[31:16] : i_raw[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_LB:   o_data = XLEN'(w_byte);
            F3_LH:   o_data = XLEN'(w_half);
            F3_LBU:  o_data = XLEN'($unsigned(w_byte));
            F3_LHU:  o_data = XLEN'($unsigned(w_half));
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: valid/ready request, valid-only response, stall
// generation and load formatting. Define MEM_TIMEOUT_EN to build the response watchdog.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            reg_write_in,
    input  logic [2:0]      funct3_in,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_data,
    output logic [XLEN-1:0] mem_rdata_out,
    output logic            reg_write_out,
    output logic            fault_out,
    output logic            stall_out,
    output logic            bus_err_out
);

    mau_state_t      r_state;
    logic [XLEN-1:0] r_rdata;

    logic            w_active;
    logic            w_fault;
    logic            w_go;
    logic            w_is_load;
    logic [1:0]      w_off;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_aligned;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

    assign w_off     = alu_result_in[1:0];
    assign w_active  = mem_read_in | mem_write_in;
    assign w_fault   = w_active & (f3_illegal(funct3_in) | f3_misaligned(funct3_in, w_off));
    assign w_go      = w_active & ~w_fault;
    assign w_is_load = mem_read_in & ~mem_write_in;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2_data_in;
        case (funct3_in[1:0])
            F3_SB[1:0]: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{rs2_data_in[7:0]}};
            end
            F3_SH[1:0]: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{rs2_data_in[15:0]}};
            end
            F3_SW[1:0]: w_wdata = rs2_data_in;
            default:    w_wdata = rs2_data_in;
        endcase
    end

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .i_raw   (dmem_rsp_data),
        .i_off   (w_off),
        .i_funct3(funct3_in),
        .o_data  (w_aligned)
    );

    // Request fields follow the held EX/MEM inputs, so they stay stable while ready is low.
    assign dmem_req_valid = (r_state == IDLE) & w_go;
    assign dmem_addr      = {alu_result_in[XLEN-1:2], 2'b00};
    assign dmem_we        = w_go & mem_write_in;
    assign dmem_be        = w_go ? w_be : 4'b0000;
    assign dmem_wdata     = w_wdata;

    assign stall_out      = ((r_state == IDLE) & w_go) | (r_state == WAIT_RSP);
    assign fault_out      = w_fault;
    assign reg_write_out  = reg_write_in & ~w_fault;
    assign mem_rdata_out  = r_rdata;

`ifdef MEM_TIMEOUT_EN
    assign bus_err_out = r_bus_err;
`else
    assign bus_err_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rdata   <= '0;
`ifdef MEM_TIMEOUT_EN
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_go && dmem_req_ready) r_state <= WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        if (w_is_load) r_rdata <= w_aligned;
                        r_state <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rdata   <= '0;
                        r_bus_err <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                // The EX/MEM inputs still show the finished access here, so no request.
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases with literal expectations plus a
// randomized run against a transaction-level model, checked every cycle.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int TO = 8;
`ifdef MEM_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result_in, rs2_data_in;
    logic        mem_read_in, mem_write_in, reg_write_in;
    logic [2:0]  funct3_in;
    logic        dmem_req_valid, dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_data;
    logic [31:0] mem_rdata_out;
    logic        reg_write_out, fault_out, stall_out, bus_err_out;

    int n_total = 0;
    int n_bad   = 0;
    int n_buserr = 0;
    bit chk_en  = 0;

    bit          cfg_rand  = 0;
    bit          cfg_ready = 1;
    int          cfg_delay = 1;
    logic [31:0] cfg_rdata = 32'h0;

    // transaction-level model state
    bit          m_out    = 0;
    bit          m_done   = 0;
    bit          m_buserr = 0;
    int          m_wait   = 0;
    logic [31:0] m_rdata  = 32'h0;

    mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in), .funct3_in(funct3_in),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rsp_data(dmem_rsp_data), .mem_rdata_out(mem_rdata_out),
        .reg_write_out(reg_write_out), .fault_out(fault_out),
        .stall_out(stall_out), .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---- model: access rules from size/alignment arithmetic ----
    function automatic logic [31:0] size_bytes();
        return 32'd1 << funct3_in[1:0];
    endfunction

    function automatic bit m_fault();
        if (!(mem_read_in || mem_write_in)) return 0;
        if (funct3_in == 3'd3 || funct3_in == 3'd6 || funct3_in == 3'd7) return 1;
        return (alu_result_in % size_bytes()) != 32'd0;
    endfunction

    function automatic bit m_go();
        return (mem_read_in || mem_write_in) && !m_fault();
    endfunction

    function automatic bit m_req();
        return m_go() && !m_out && !m_done;
    endfunction

    function automatic logic [3:0] m_be();
        logic [31:0] mask;
        mask = ((32'd1 << size_bytes()) - 32'd1) << alu_result_in[1:0];
        return mask[3:0];
    endfunction

    function automatic logic [31:0] m_wdata();
        if (size_bytes() == 32'd1) return {24'd0, rs2_data_in[7:0]} * 32'h01010101;
        if (size_bytes() == 32'd2) return {16'd0, rs2_data_in[15:0]} * 32'h00010001;
        return rs2_data_in;
    endfunction

    function automatic logic [31:0] m_fmt(input logic [31:0] raw);
        logic [31:0]        v;
        logic signed [31:0] s;
        v = raw >> {alu_result_in[1:0], 3'b000};
        case (funct3_in)
            3'd0:    begin s = $signed(v[7:0]);  return s; end
            3'd1:    begin s = $signed(v[15:0]); return s; end
            3'd4:    return {24'd0, v[7:0]};
            3'd5:    return {16'd0, v[15:0]};
            default: return raw;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_out = 0; m_done = 0; m_rdata = 32'h0; m_wait = 0; m_buserr = 0;
        end else begin
            m_buserr = 0;
            if (m_done) begin
                m_done = 0;
            end else if (m_out) begin
                if (dmem_rsp_valid) begin
                    m_out = 0; m_done = 1;
                    if (mem_read_in && !mem_write_in) m_rdata = m_fmt(dmem_rsp_data);
                end else if (TIMEOUT_ON && m_wait == TO - 1) begin
                    m_out = 0; m_done = 1; m_rdata = 32'h0; m_buserr = 1;
                end else begin
                    m_wait++;
                end
            end else if (m_req() && dmem_req_ready) begin
                m_out = 1; m_wait = 0;
            end
        end
    end

    // ---- compare every cycle ----
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("fault", fault_out, m_fault());
            chk1("req_valid", dmem_req_valid, m_req());
            chk1("stall", stall_out, m_req() || m_out);
            chk1("reg_write", reg_write_out, reg_write_in && !m_fault());
            chk32("rdata", mem_rdata_out, m_rdata);
            chk1("bus_err", bus_err_out, m_buserr);
            if (m_req()) begin
                chk32("addr", dmem_addr, {alu_result_in[31:2], 2'b00});
                chk1("we", dmem_we, mem_write_in);
                chk32("be", {28'd0, dmem_be}, {28'd0, m_be()});
                chk32("wdata", dmem_wdata, m_wdata());
            end
        end
        if (bus_err_out === 1'b1) n_buserr++;
    end

    // ---- memory responder ----
    initial begin : mem_proc
        int cd;
        bit acc;
        cd = 0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            acc = dmem_req_valid && dmem_req_ready && !rst;
            #1;
            dmem_rsp_valid = 1'b0;
            dmem_req_ready = cfg_rand ? ($urandom_range(0, 3) != 0) : cfg_ready;
            if (acc) cd = cfg_rand ? int'($urandom_range(1, 3)) : cfg_delay;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    dmem_rsp_valid = 1'b1;
                    dmem_rsp_data  = cfg_rand ? $urandom : cfg_rdata;
                end
            end else if (cfg_rand && !acc && $urandom_range(0, 9) == 0) begin
                dmem_req_ready = 1'b0;
                dmem_rsp_valid = 1'b1;
                dmem_rsp_data  = $urandom;
            end
        end
    end

    task automatic instr(input logic [31:0] a, input logic [31:0] d, input logic rd,
                         input logic wr, input logic rw, input logic [2:0] f3, output int stalls);
        bit fin;
        fin = 0;
        stalls = 0;
        alu_result_in = a; rs2_data_in = d; mem_read_in = rd;
        mem_write_in = wr; reg_write_in = rw; funct3_in = f3;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            if (stall_out) stalls++;
            else fin = 1;
        end
        n_total++;
        if (!fin) begin
            n_bad++;
            $display("FAIL retire actual=stalled required=retired t=%0t", $time);
        end
        @(posedge clk);
        #1;
        mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int st;
        rst = 1'b1;
        alu_result_in = 32'h0; rs2_data_in = 32'h0; mem_read_in = 1'b0;
        mem_write_in = 1'b0; reg_write_in = 1'b0; funct3_in = 3'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk32("rst_rdata", mem_rdata_out, 32'h0);
        chk1("rst_stall", stall_out, 1'b0);
        chk1("rst_valid", dmem_req_valid, 1'b0);
        chk1("rst_buserr", bus_err_out, 1'b0);
        @(posedge clk);
        #1;

        // SW 0x100
        cfg_delay = 1;
        fork
            instr(32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, F3_SW, st);
            begin
                @(negedge clk);
                chk1("sw_valid", dmem_req_valid, 1'b1);
                chk32("sw_be", {28'd0, dmem_be}, 32'hF);
                chk32("sw_wdata", dmem_wdata, 32'hDEADBEEF);
                chk1("sw_we", dmem_we, 1'b1);
            end
        join
        chk32("sw_stalls", st, 32'd2);

        // LB / LBU at 0x203
        cfg_rdata = 32'h80112233;
        fork
            instr(32'h203, 32'h0, 1'b1, 1'b0, 1'b1, F3_LB, st);
            begin
                @(negedge clk);
                chk32("lb_be", {28'd0, dmem_be}, 32'h8);
                chk32("lb_addr", dmem_addr, 32'h200);
            end
        join
        chk32("lb_rdata", mem_rdata_out, 32'hFFFFFF80);
        instr(32'h203, 32'h0, 1'b1, 1'b0, 1'b1, F3_LBU, st);
        chk32("lbu_rdata", mem_rdata_out, 32'h00000080);

        // misaligned LHU
        fork
            instr(32'h101, 32'h0, 1'b1, 1'b0, 1'b1, F3_LHU, st);
            begin
                @(negedge clk);
                chk1("lhu_fault", fault_out, 1'b1);
                chk1("lhu_regwr", reg_write_out, 1'b0);
                chk1("lhu_valid", dmem_req_valid, 1'b0);
            end
        join
        chk32("lhu_stalls", st, 32'd0);
        chk32("lhu_rdata_kept", mem_rdata_out, 32'h00000080);

        // LW with ready low for 3 cycles, response 2 cycles after acceptance
        cfg_ready = 1'b0; cfg_delay = 2; cfg_rdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        fork
            instr(32'h204, 32'h0, 1'b1, 1'b0, 1'b1, F3_LW, st);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk1("lw_hold_valid", dmem_req_valid, 1'b1);
                    chk32("lw_hold_addr", dmem_addr, 32'h204);
                    chk32("lw_hold_be", {28'd0, dmem_be}, 32'hF);
                    chk1("lw_hold_stall", stall_out, 1'b1);
                end
                cfg_ready = 1'b1;
            end
        join
        chk32("lw_stalls", st, 32'd6);
        chk32("lw_rdata", mem_rdata_out, 32'hCAFEF00D);

        // reset while waiting for a response; the late response lands in IDLE
        cfg_delay = 3; cfg_rdata = 32'h12345678;
        alu_result_in = 32'h300; mem_read_in = 1'b1; reg_write_in = 1'b1; funct3_in = F3_LW;
        @(negedge clk);
        chk1("rst_mid_valid", dmem_req_valid, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mem_read_in = 1'b0; reg_write_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk32("rst_mid_rdata", mem_rdata_out, 32'h0);
            chk1("rst_mid_stall", stall_out, 1'b0);
        end
        @(posedge clk);
        #1;
        cfg_delay = 1;
        instr(32'h104, 32'h000000A5, 1'b0, 1'b1, 1'b0, F3_SB, st);
        chk32("post_rst_stalls", st, 32'd2);

`ifdef MEM_TIMEOUT_EN
        cfg_rdata = 32'h0BADF00D;
        instr(32'h400, 32'h0, 1'b1, 1'b0, 1'b1, F3_LW, st);
        chk32("to_pre_rdata", mem_rdata_out, 32'h0BADF00D);
        cfg_delay = 0;
        n_buserr = 0;
        instr(32'h404, 32'h0, 1'b1, 1'b0, 1'b1, F3_LW, st);
        chk32("to_stalls", st, 32'd9);
        chk32("to_buserr_cycles", n_buserr, 32'd1);
        chk32("to_rdata", mem_rdata_out, 32'h0);
        cfg_delay = 1;
`endif

        // randomized traffic
        cfg_rand = 1'b1;
        for (int k = 0; k < 300; k++) begin
            int kind;
            kind = int'($urandom_range(0, 4));
            instr($urandom, $urandom, (kind < 2), (kind == 2 || kind == 3),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), st);
        end
        cfg_rand = 1'b0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
